// File: rtl/cofre_if.sv
// Keypad/sensor inputs and lock/display outputs of the safe controller.
// digit_valid is a one-cycle strobe with no ready: a digit offered outside CLOSED/PROG is dropped.
interface cofre_if #(
  parameter int DIGIT_W   = 4,
  parameter int N_DIGITS  = 4,
  parameter int MAX_TRIES = 3
);
  localparam int ERR_W = $clog2(MAX_TRIES + 1);
  localparam int DIG_W = $clog2(N_DIGITS + 1);

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               close_req;
  logic               remote_mode;
  logic               remote_open;
  logic               pin_ok;
  logic               master_key;
  logic               prog_req;

  logic               close;
  logic [2:0]         state;
  logic [ERR_W-1:0]   err_count;
  logic [DIG_W-1:0]   digits_in;
  logic               pwd_ok;
  logic               pwd_fail;
  logic               alarm;

  modport master (
    output digit_valid, digit, close_req, remote_mode, remote_open, pin_ok, master_key, prog_req,
    input  close, state, err_count, digits_in, pwd_ok, pwd_fail, alarm
  );

  modport slave (
    input  digit_valid, digit, close_req, remote_mode, remote_open, pin_ok, master_key, prog_req,
    output close, state, err_count, digits_in, pwd_ok, pwd_fail, alarm
  );
endinterface

// File: rtl/cofre_multi.sv
// Safe controller: serial password entry, attempt limit with timed lockout, and
// in-field password programming. The state register doubles as the debug view.
module cofre_multi #(
  parameter int                         DIGIT_W        = 4,
  parameter int                         N_DIGITS       = 4,
  parameter int                         MAX_TRIES      = 3,
  parameter int                         LOCKOUT_CYCLES = 1024,
  parameter logic [DIGIT_W*N_DIGITS-1:0] SECRET_INIT   = 16'h1234
) (
  input  logic    clk,
  input  logic    reset,
  cofre_if.slave  bus
);
  localparam int PW_W  = DIGIT_W * N_DIGITS;
  localparam int ERR_W = $clog2(MAX_TRIES + 1);
  localparam int DIG_W = $clog2(N_DIGITS + 1);
  localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [2:0] S_OPEN    = 3'd0;
  localparam logic [2:0] S_CLOSED  = 3'd1;
  localparam logic [2:0] S_REMOTE  = 3'd2;
  localparam logic [2:0] S_LOCKOUT = 3'd3;
  localparam logic [2:0] S_PROG    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [PW_W-1:0]  buf_q, buf_d;
  logic [PW_W-1:0]  secret_q, secret_d;
  logic [LCK_W-1:0] lock_q, lock_d;
  logic             ok_q, ok_d;
  logic             fail_q, fail_d;
  logic             close_q, alarm_q;

  logic [PW_W-1:0]  new_buf;
  logic             last_digit;

  assign new_buf    = (buf_q << DIGIT_W) | PW_W'(bus.digit);
  assign last_digit = bus.digit_valid && (dig_q == DIG_W'(N_DIGITS - 1));

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    dig_d    = dig_q;
    buf_d    = buf_q;
    secret_d = secret_q;
    lock_d   = lock_q;
    ok_d     = 1'b0;
    fail_d   = 1'b0;

    case (state_q)
      S_OPEN: begin
        if (bus.prog_req)
          state_d = S_PROG;
        else if (bus.close_req && bus.pin_ok)
          state_d = bus.remote_mode ? S_REMOTE : S_CLOSED;
      end
      S_CLOSED: begin
        if (last_digit) begin
          dig_d = '0;
          buf_d = '0;
          if (new_buf == secret_q) begin
            ok_d = 1'b1;
            if (bus.pin_ok) begin
              state_d = S_OPEN;
              err_d   = '0;
            end
          end else begin
            fail_d = 1'b1;
            err_d  = err_q + 1'b1;
            // err_q never exceeds MAX_TRIES-1 here, so the increment saturates at MAX_TRIES.
            if (err_q == ERR_W'(MAX_TRIES - 1)) begin
              state_d = S_LOCKOUT;
              lock_d  = LCK_W'(LOCKOUT_CYCLES);
            end
          end
        end else if (bus.digit_valid) begin
          dig_d = dig_q + 1'b1;
          buf_d = new_buf;
        end
      end
      S_REMOTE: begin
        if (bus.remote_open)
          state_d = S_OPEN;
      end
      S_LOCKOUT: begin
        lock_d = lock_q - 1'b1;
        if (lock_q == LCK_W'(1)) begin
          state_d = S_CLOSED;
          err_d   = '0;
        end
      end
      S_PROG: begin
        if (bus.close_req) begin
          state_d = S_OPEN;
        end else if (last_digit) begin
          secret_d = new_buf;
          ok_d     = 1'b1;
          state_d  = S_OPEN;
        end else if (bus.digit_valid) begin
          dig_d = dig_q + 1'b1;
          buf_d = new_buf;
        end
      end
      default: state_d = S_OPEN;
    endcase

    if (state_d != state_q) begin
      buf_d = '0;
      dig_d = '0;
    end

    if (bus.master_key) begin
      state_d = S_OPEN;
      err_d   = '0;
      dig_d   = '0;
      buf_d   = '0;
      lock_d  = '0;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_OPEN;
      err_q    <= '0;
      dig_q    <= '0;
      buf_q    <= '0;
      secret_q <= SECRET_INIT;
      lock_q   <= '0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
      close_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      dig_q    <= dig_d;
      buf_q    <= buf_d;
      secret_q <= secret_d;
      lock_q   <= lock_d;
      ok_q     <= ok_d;
      fail_q   <= fail_d;
      close_q  <= (state_d == S_CLOSED) || (state_d == S_REMOTE) || (state_d == S_LOCKOUT);
      alarm_q  <= (state_d == S_LOCKOUT);
    end
  end

  assign bus.state     = state_q;
  assign bus.close     = close_q;
  assign bus.err_count = err_q;
  assign bus.digits_in = dig_q;
  assign bus.pwd_ok    = ok_q;
  assign bus.pwd_fail  = fail_q;
  assign bus.alarm     = alarm_q;
endmodule

// File: tb/tb_cofre_multi.sv
// Directed bench for cofre_multi with hand-computed expectations.
module tb_cofre_multi;
  localparam int DIGIT_W = 4;
  localparam int N_DIGITS = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT_CYCLES = 8;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [2:0] exp_q[$];

  cofre_if #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .MAX_TRIES(MAX_TRIES)) bus ();

  cofre_multi #(
    .DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .MAX_TRIES(MAX_TRIES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .SECRET_INIT(16'h1234)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit = d;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic send_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) send_digit(code[i*4 +: 4]);
  endtask

  task automatic do_close(input logic remote);
    bus.close_req = 1'b1;
    bus.remote_mode = remote;
    tick();
    bus.close_req = 1'b0;
    bus.remote_mode = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit = '0;
    bus.close_req = 1'b0;
    bus.remote_mode = 1'b0;
    bus.remote_open = 1'b0;
    bus.pin_ok = 1'b1;
    bus.master_key = 1'b0;
    bus.prog_req = 1'b0;

    #2;
    check("rst_state", 32'(bus.state), 0);
    check("rst_close", 32'(bus.close), 0);
    check("rst_outs", {bus.err_count, bus.digits_in, bus.pwd_ok, bus.pwd_fail, bus.alarm}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    // open -> closed, correct code
    do_close(1'b0);
    check("close_state", 32'(bus.state), 1);
    check("close_pin", 32'(bus.close), 1);
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    check("digits3", 32'(bus.digits_in), 3);
    send_digit(4'd4);
    check("ok_pulse", 32'(bus.pwd_ok), 1);
    check("ok_state", 32'(bus.state), 0);
    check("ok_close", 32'(bus.close), 0);
    check("ok_digits", 32'(bus.digits_in), 0);
    tick();
    check("ok_width", 32'(bus.pwd_ok), 0);

    // three wrong codes -> lockout
    do_close(1'b0);
    send_code(16'h0000);
    check("fail1_pulse", 32'(bus.pwd_fail), 1);
    check("fail1_err", 32'(bus.err_count), 1);
    check("fail1_state", 32'(bus.state), 1);
    send_code(16'h0000);
    check("fail2_err", 32'(bus.err_count), 2);
    send_code(16'h0000);
    check("lock_state", 32'(bus.state), 3);
    check("lock_alarm", 32'(bus.alarm), 1);
    check("lock_err", 32'(bus.err_count), 3);
    check("lock_close", 32'(bus.close), 1);
    for (int i = 0; i < LOCKOUT_CYCLES - 1; i++) exp_q.push_back(3'd3);
    exp_q.push_back(3'd1);
    while (exp_q.size() > 0) begin
      tick();
      check("lock_trace", 32'(bus.state), 32'(exp_q.pop_front()));
    end
    check("unlock_err", 32'(bus.err_count), 0);
    check("unlock_alarm", 32'(bus.alarm), 0);

    // one wrong, then correct code with unhealthy pin
    send_code(16'h5555);
    check("pin_pre_err", 32'(bus.err_count), 1);
    bus.pin_ok = 1'b0;
    send_code(16'h1234);
    check("pin_ok_pulse", 32'(bus.pwd_ok), 1);
    check("pin_state", 32'(bus.state), 1);
    check("pin_err", 32'(bus.err_count), 1);
    bus.pin_ok = 1'b1;

    // master key after two digits
    send_digit(4'd1); send_digit(4'd2);
    check("mk_digits_pre", 32'(bus.digits_in), 2);
    bus.master_key = 1'b1;
    tick();
    bus.master_key = 1'b0;
    check("mk_state", 32'(bus.state), 0);
    check("mk_err", 32'(bus.err_count), 0);
    check("mk_digits", 32'(bus.digits_in), 0);
    check("mk_close", 32'(bus.close), 0);
    check("mk_pulses", {bus.pwd_ok, bus.pwd_fail}, 0);

    // program new password 9876 (prog_req wins over close_req)
    bus.prog_req = 1'b1;
    bus.close_req = 1'b1;
    tick();
    bus.prog_req = 1'b0;
    bus.close_req = 1'b0;
    check("prog_state", 32'(bus.state), 4);
    check("prog_close", 32'(bus.close), 0);
    send_code(16'h9876);
    check("prog_ok", 32'(bus.pwd_ok), 1);
    check("prog_done", 32'(bus.state), 0);
    do_close(1'b0);
    send_code(16'h1234);
    check("old_pw_fail", 32'(bus.pwd_fail), 1);
    check("old_pw_err", 32'(bus.err_count), 1);
    send_code(16'h9876);
    check("new_pw_ok", 32'(bus.pwd_ok), 1);
    check("new_pw_state", 32'(bus.state), 0);
    check("new_pw_err", 32'(bus.err_count), 0);

    // remote mode
    do_close(1'b1);
    check("remote_state", 32'(bus.state), 2);
    check("remote_close", 32'(bus.close), 1);
    send_code(16'h1234);
    check("remote_digits", 32'(bus.digits_in), 0);
    check("remote_hold", 32'(bus.state), 2);
    bus.remote_open = 1'b1;
    tick();
    bus.remote_open = 1'b0;
    check("remote_open", 32'(bus.state), 0);

    // master key during lockout
    do_close(1'b0);
    repeat (3) send_code(16'h0000);
    tick();
    check("lock2_state", 32'(bus.state), 3);
    bus.master_key = 1'b1;
    tick();
    bus.master_key = 1'b0;
    check("mk_lock_state", 32'(bus.state), 0);
    check("mk_lock_alarm", 32'(bus.alarm), 0);
    check("mk_lock_err", 32'(bus.err_count), 0);
    check("mk_lock_close", 32'(bus.close), 0);

    // asynchronous reset mid-entry, secret returns to 1234
    do_close(1'b0);
    send_digit(4'd1); send_digit(4'd2);
    #2 reset = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 0);
    check("arst_digits", 32'(bus.digits_in), 0);
    check("arst_close", 32'(bus.close), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("arst_after", 32'(bus.state), 0);
    do_close(1'b0);
    send_code(16'h1234);
    check("arst_secret", 32'(bus.pwd_ok), 1);
    check("arst_open", 32'(bus.state), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/cofre_multi.md
# cofre_multi

Parametrised next-generation safe controller. Digits are entered serially, so password length and digit width are configurable. It adds a configurable attempt limit with a timed lockout, and an in-field password programming mode while open. It sits between the debounced keypad/sensor front end and the display decoder/lock actuator, and runs on the divided (slow) clock.

## Interface
Parameters:
- DIGIT_W, 4: bits per entered digit.
- N_DIGITS, 4: digits per password; PW_W = DIGIT_W*N_DIGITS.
- MAX_TRIES, 3: consecutive wrong codes that trigger lockout (≥1).
- LOCKOUT_CYCLES, 1024: clk cycles spent in LOCKOUT (≥1).
- SECRET_INIT, 16'h1234 (PW_W bits): password loaded at reset. The first digit entered is the most-significant digit.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- digit_valid  in  1  one-cycle strobe; digit is sampled on this cycle.
- digit  in  DIGIT_W  entered digit.
- close_req  in  1  request to close (button B).
- remote_mode  in  1  1 = close into remote-only mode (A).
- remote_open  in  1  remote open command (SAF).
- pin_ok  in  1  locking pin sensor is healthy (SPN).
- master  in  1  master key (H), sampled synchronously.
- prog_req  in  1  request to program a new password.
- close  out  1  drives the lock pin.
- state  out  3  0 OPEN, 1 CLOSED, 2 REMOTE, 3 LOCKOUT, 4 PROG.
- err_count  out  $clog2(MAX_TRIES+1)  consecutive wrong codes.
- digits_in  out  $clog2(N_DIGITS+1)  digits buffered so far.
- pwd_ok  out  1  one-cycle pulse: full code matched.
- pwd_fail  out  1  one-cycle pulse: full code mismatched.
- alarm  out  1  high while in LOCKOUT.

## Operation
- Reset (reset=0) sets every output to its reset value, immediately and asynchronously:
  - state=OPEN, close=0, err_count=0, digits_in=0, pwd_ok=0, pwd_fail=0, alarm=0.
  - The secret register is set to SECRET_INIT; the lockout counter is set to 0.
- Digit entry applies in CLOSED and PROG only:
  - Each digit_valid shifts digit into the entry buffer and increments digits_in.
  - digit_valid in any other state is ignored.
- In CLOSED, the entry completes when the N_DIGITS-th digit arrives:
  - match and pin_ok=1: pwd_ok=1, go to OPEN, err_count=0.
  - match and pin_ok=0: pwd_ok=1, stay CLOSED, err_count unchanged.
  - mismatch: pwd_fail=1 and err_count+1. When err_count reaches MAX_TRIES, go to LOCKOUT and load the counter with LOCKOUT_CYCLES; otherwise stay CLOSED.
  - In every case digits_in returns to 0.
- OPEN state:
  - close_req=1 and pin_ok=1 goes to CLOSED if remote_mode=0, or to REMOTE if remote_mode=1.
  - prog_req=1 goes to PROG. If prog_req and close_req are both high, prog_req wins.
- REMOTE state: remote_open=1 goes to OPEN. Digits are ignored.
- LOCKOUT state:
  - The counter decrements every cycle.
  - On the cycle it reaches 1, go to CLOSED with err_count=0.
  - alarm=1 throughout LOCKOUT.
- PROG state:
  - The N_DIGITS-th digit writes the buffer (including that digit) into the secret, pulses pwd_ok, and returns to OPEN.
  - close_req in PROG aborts: buffer discarded, go to OPEN.
- close = 1 in CLOSED, REMOTE and LOCKOUT, and 0 in OPEN and PROG.
- master=1 has priority over everything except reset:
  - Next state is OPEN; err_count, digits_in and the lockout counter are cleared; no pwd_ok or pwd_fail pulse.
  - The secret is unchanged.
- Every state change clears the entry buffer and digits_in.
- Wrap-around is impossible by construction:
  - err_count saturates at MAX_TRIES.
  - digits_in never exceeds N_DIGITS−1 between edges.

## Timing
- All outputs are registered.
- Digit buffering: digits_in updates at the edge that samples digit_valid.
- The code-complete decision takes effect at the same edge that samples the N_DIGITS-th digit:
  - state, close, err_count, alarm and the pulses all reflect the decision in the following cycle.
  - Latency is 1 clk from the last digit to the response.
- pwd_ok and pwd_fail are exactly one cycle wide and never high together.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles with state=3; alarm falls together with the state change.
- A back-to-back digit_valid on the cycle right after a completed entry belongs to the new entry, provided the state still accepts digits.
- Reset asserted mid-entry or mid-lockout aborts immediately; after release, the first edge acts from OPEN.

## Test plan
- Reset, close_req with pin_ok=1, remote_mode=0, then enter 1,2,3,4 → state 1 then 0, pwd_ok pulse one cycle after digit 4, close 1→0.
- From CLOSED, enter 3 wrong codes (0,0,0,0) with MAX_TRIES=3 → err_count 1, 2, then state=3, alarm=1 for LOCKOUT_CYCLES (set 8 on the bench), then state=1, err_count=0.
- Open, prog_req, enter 9,8,7,6 → state 4 then 0. Close, enter 1,2,3,4 → pwd_fail. Enter 9,8,7,6 → OPEN.
- close_req with remote_mode=1 → state 2. Digits 1,2,3,4 are ignored (digits_in=0). remote_open → state 0.
- master=1 during LOCKOUT, and separately after 2 entered digits in CLOSED → state 0 next cycle, err_count=0, digits_in=0, close=0, no pulses.
- Correct code with pin_ok=0 → pwd_ok pulse, state stays 1, err_count unchanged. Reset pulse mid-entry → all outputs at reset values asynchronously.
